wasm_loader: RTL and testbench

Streaming program loader for the wasmachine memory subsystem: accepts a WebAssembly binary one byte at a time over a valid/ready stream, writes it into program memory through a byte-wide write port, and holds the CPU in reset until the image is committed. It is the writer-side counterpart of the CPU's `genrom` fetch path. It sits between a host/UART byte source and the program RAM, and drives the CPU's `reset` input.

---
 rtl/wasm_loader_pkg.sv | 23 ++
 rtl/wasm_loader_leb128.sv | 39 +++
 rtl/wasm_loader.sv | 217 +++++++++++++++++++++
 tb/tb_wasm_loader.sv | 116 +++++++++++
 4 files changed

// File: rtl/wasm_loader_pkg.sv
// Shared definitions for the wasm_loader program loader: state encodings,
// abort causes and LEB128 header sizing.
package wasm_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_LOAD   = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        LD_OK           = 2'd0,
        LD_OOB          = 2'd1,
        LD_LEN_OVF      = 2'd2,
        LD_LEN_MISMATCH = 2'd3
    } ld_code_t;

    localparam int LEB_MAX_BYTES = 5;
    localparam int LEB_W         = 7 * LEB_MAX_BYTES;

endpackage

// File: rtl/wasm_loader_leb128.sv
// leb128_decoder: byte-serial unsigned LEB128 accumulator. value/complete/overflow
// reflect the byte currently presented, so the caller can act in the same cycle.
module leb128_decoder
    import wasm_loader_pkg::*;
#(
    parameter int W = LEB_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         byte_valid,
    input  logic [7:0]   byte_in,
    output logic [W-1:0] value,
    output logic         complete,
    output logic         overflow
);

    logic [W-1:0] acc_r;
    logic [2:0]   idx_r;

    // Merge the current 7-bit group into the running value
    always_comb begin
        value    = acc_r | (W'(byte_in[6:0]) << (7 * idx_r));
        overflow = byte_valid & byte_in[7] & (idx_r == 3'(LEB_MAX_BYTES - 1));
        complete = byte_valid & ~byte_in[7] & ~overflow;
    end

    // Accumulator and group index
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc_r <= '0;
            idx_r <= 3'd0;
        end else if (byte_valid) begin
            acc_r <= value;
            idx_r <= idx_r + 3'd1;
        end
    end

endmodule

// File: rtl/wasm_loader.sv
// wasm_loader: streams a WebAssembly image into program RAM and holds the CPU in
// reset until committed. Optional LEB128 length header: LOADER_LEB128_HEADER_EN.
module wasm_loader
    import wasm_loader_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   lower_bound,
    input  logic [AW:0]   upper_bound,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW:0]   mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [1:0]    error_code,
    output logic [AW+1:0] count
);

    localparam int CW = AW + 2;

    state_t        state_r, state_s;
    logic [AW:0]   lower_r, upper_r, lower_s, upper_s;
    logic          in_ready_s, mem_we_s, cpu_reset_s, busy_s, done_s, error_s;
    logic [AW:0]   mem_addr_s;
    logic [7:0]    mem_wdata_s;
    logic [1:0]    error_code_s;
    logic [CW-1:0] count_s, target_s;
    logic          accept_s, in_range_s, abort_s;
    ld_code_t      abort_code_s;

    assign accept_s   = in_valid & in_ready;
    // Target is one bit wider than the address so it can never wrap
    assign target_s   = {1'b0, lower_r} + count;
    assign in_range_s = (target_s <= {1'b0, upper_r});

`ifdef LOADER_LEB128_HEADER_EN
    logic [CW-1:0]    len_r, len_s, span_s;
    logic [LEB_W-1:0] leb_value_s;
    logic             leb_complete_s, leb_overflow_s;

    assign span_s = (lower_r > upper_r) ? CW'(0)
                  : ({1'b0, upper_r} - {1'b0, lower_r} + CW'(1));

    leb128_decoder #(.W(LEB_W)) u_leb (
        .clk        (clk),
        .reset      (reset),
        .clear      (state_r != ST_HEADER),
        .byte_valid (accept_s && (state_r == ST_HEADER)),
        .byte_in    (in_data),
        .value      (leb_value_s),
        .complete   (leb_complete_s),
        .overflow   (leb_overflow_s)
    );

    // Expected payload length captured from the header
    always_ff @(posedge clk) begin
        if (reset) len_r <= '0;
        else       len_r <= len_s;
    end
`endif

    // Next-state and next-output logic; all outputs are registered below
    always_comb begin
        state_s      = state_r;
        lower_s      = lower_r;
        upper_s      = upper_r;
        in_ready_s   = in_ready;
        mem_we_s     = 1'b0;
        mem_addr_s   = mem_addr;
        mem_wdata_s  = mem_wdata;
        cpu_reset_s  = cpu_reset;
        busy_s       = busy;
        done_s       = done;
        error_s      = error;
        error_code_s = error_code;
        count_s      = count;
        abort_s      = 1'b0;
        abort_code_s = LD_OK;
`ifdef LOADER_LEB128_HEADER_EN
        len_s        = len_r;
`endif
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    lower_s      = lower_bound;
                    upper_s      = upper_bound;
                    count_s      = '0;
                    done_s       = 1'b0;
                    error_s      = 1'b0;
                    error_code_s = LD_OK;
                    cpu_reset_s  = 1'b1;
                    busy_s       = 1'b1;
                    in_ready_s   = 1'b1;
`ifdef LOADER_LEB128_HEADER_EN
                    state_s      = ST_HEADER;
`else
                    state_s      = ST_LOAD;
`endif
                end else if (state_r == ST_DONE) begin
                    // Completion shows one edge after entry, once the last write has committed
                    done_s      = 1'b1;
                    cpu_reset_s = 1'b0;
                    busy_s      = 1'b0;
                    in_ready_s  = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
`ifdef LOADER_LEB128_HEADER_EN
            ST_HEADER: begin
                if (accept_s) begin
                    if (leb_overflow_s) begin
                        abort_s = 1'b1; abort_code_s = LD_LEN_OVF;
                    end else if (leb_complete_s) begin
                        if (leb_value_s > LEB_W'(span_s)) begin
                            abort_s = 1'b1; abort_code_s = LD_LEN_OVF;
                        end else if ((leb_value_s == LEB_W'(0)) != in_last) begin
                            abort_s = 1'b1; abort_code_s = LD_LEN_MISMATCH;
                        end else if (in_last) begin
                            state_s = ST_DONE; in_ready_s = 1'b0;
                        end else begin
                            state_s = ST_LOAD; len_s = CW'(leb_value_s);
                        end
                    end else if (in_last) begin
                        abort_s = 1'b1; abort_code_s = LD_LEN_MISMATCH;
                    end else begin
                        state_s = ST_HEADER;
                    end
                end else begin
                    state_s = ST_HEADER;
                end
            end
`endif
            ST_LOAD: begin
                if (accept_s) begin
                    if (!in_range_s) begin
                        abort_s = 1'b1; abort_code_s = LD_OOB;
`ifdef LOADER_LEB128_HEADER_EN
                    end else if (((count + CW'(1)) == len_r) != in_last) begin
                        abort_s = 1'b1; abort_code_s = LD_LEN_MISMATCH;
`endif
                    end else begin
                        mem_we_s    = 1'b1;
                        mem_addr_s  = target_s[AW:0];
                        mem_wdata_s = in_data;
                        count_s     = count + CW'(1);
                        if (in_last) begin
                            state_s    = ST_DONE;
                            in_ready_s = 1'b0;
                        end else begin
                            state_s = ST_LOAD;
                        end
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        if (abort_s) begin
            state_s      = ST_ERROR;
            error_s      = 1'b1;
            error_code_s = abort_code_s;
            cpu_reset_s  = 1'b1;
            busy_s       = 1'b0;
            in_ready_s   = 1'b0;
            mem_we_s     = 1'b0;
        end else begin
            abort_code_s = LD_OK;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            lower_r    <= '0;
            upper_r    <= '0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 8'h00;
            cpu_reset  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            error_code <= LD_OK;
            count      <= '0;
        end else begin
            state_r    <= state_s;
            lower_r    <= lower_s;
            upper_r    <= upper_s;
            in_ready   <= in_ready_s;
            mem_we     <= mem_we_s;
            mem_addr   <= mem_addr_s;
            mem_wdata  <= mem_wdata_s;
            cpu_reset  <= cpu_reset_s;
            busy       <= busy_s;
            done       <= done_s;
            error      <= error_s;
            error_code <= error_code_s;
            count      <= count_s;
        end
    end

endmodule

// File: tb/tb_wasm_loader.sv
// Directed bench for wasm_loader (default build, AW=4): vector table plus a bubble sequence.
module tb_wasm_loader;

    logic       clk = 1'b0;
    logic       reset, start, in_valid, in_last;
    logic [4:0] lower_bound, upper_bound;
    logic [7:0] in_data;
    logic       in_ready, mem_we, cpu_reset, busy, done, error;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [1:0] error_code;
    logic [5:0] count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    wasm_loader #(.AW(4)) dut (
        .clk(clk), .reset(reset), .start(start),
        .lower_bound(lower_bound), .upper_bound(upper_bound),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
        .error_code(error_code), .count(count)
    );

    typedef struct {
        logic       rst, st;
        logic [4:0] lo, hi;
        logic [7:0] d;
        logic       v, l;
        logic [26:0] exp;  // {rdy, we, addr, wdata, cpu_reset, busy, done, error, code, count}
    } vec_t;

    function automatic vec_t mk(input logic rst, st, input int lo, hi, d, input logic v, l,
                                input logic rdy, we, input int addr, wd,
                                input logic cpu, bsy, dn, err, input int code, cnt);
        vec_t t;
        t.rst = rst; t.st = st; t.lo = 5'(lo); t.hi = 5'(hi); t.d = 8'(d); t.v = v; t.l = l;
        t.exp = {rdy, we, 5'(addr), 8'(wd), cpu, bsy, dn, err, 2'(code), 6'(cnt)};
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    vec_t vecs[22];
    logic [7:0] img[4];

    initial begin
        img = '{8'h00, 8'h61, 8'h73, 8'h6D};
        //           rst st lo  hi  d      v  l   rdy we addr wd    cpu bsy dn err code cnt
        vecs[0]  = mk(1, 0, 0,  0,  'h00, 0, 0,  0, 0,  0, 'h00, 1, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0,  31, 'h00, 0, 0,  1, 0,  0, 'h00, 1, 1, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0,  0,  'h00, 1, 0,  1, 1,  0, 'h00, 1, 1, 0, 0, 0, 1);
        vecs[3]  = mk(0, 0, 0,  0,  'h61, 1, 0,  1, 1,  1, 'h61, 1, 1, 0, 0, 0, 2);
        vecs[4]  = mk(0, 0, 0,  0,  'h73, 1, 0,  1, 1,  2, 'h73, 1, 1, 0, 0, 0, 3);
        vecs[5]  = mk(0, 0, 0,  0,  'h6D, 1, 1,  0, 1,  3, 'h6D, 1, 1, 0, 0, 0, 4);
        vecs[6]  = mk(0, 0, 0,  0,  'h00, 0, 0,  0, 0,  3, 'h6D, 0, 0, 1, 0, 0, 4);
        vecs[7]  = mk(0, 0, 0,  0,  'h00, 0, 0,  0, 0,  3, 'h6D, 0, 0, 1, 0, 0, 4);
        vecs[8]  = mk(0, 1, 0,  31, 'h00, 0, 0,  1, 0,  3, 'h6D, 1, 1, 0, 0, 0, 0);
        vecs[9]  = mk(1, 0, 0,  0,  'h00, 0, 0,  0, 0,  0, 'h00, 1, 0, 0, 0, 0, 0);
        vecs[10] = mk(0, 1, 28, 29, 'h00, 0, 0,  1, 0,  0, 'h00, 1, 1, 0, 0, 0, 0);
        vecs[11] = mk(0, 0, 0,  0,  'hAA, 1, 0,  1, 1, 28, 'hAA, 1, 1, 0, 0, 0, 1);
        vecs[12] = mk(0, 0, 0,  0,  'hBB, 1, 0,  1, 1, 29, 'hBB, 1, 1, 0, 0, 0, 2);
        vecs[13] = mk(0, 0, 0,  0,  'hCC, 1, 0,  0, 0, 29, 'hBB, 1, 0, 0, 1, 1, 2);
        vecs[14] = mk(0, 0, 0,  0,  'hCC, 1, 0,  0, 0, 29, 'hBB, 1, 0, 0, 1, 1, 2);
        vecs[15] = mk(0, 1, 5,  4,  'h00, 0, 0,  1, 0, 29, 'hBB, 1, 1, 0, 0, 0, 0);
        vecs[16] = mk(0, 0, 0,  0,  'h11, 1, 0,  0, 0, 29, 'hBB, 1, 0, 0, 1, 1, 0);
        vecs[17] = mk(0, 1, 0,  31, 'h00, 0, 0,  1, 0, 29, 'hBB, 1, 1, 0, 0, 0, 0);
        vecs[18] = mk(0, 0, 0,  0,  'h01, 1, 0,  1, 1,  0, 'h01, 1, 1, 0, 0, 0, 1);
        vecs[19] = mk(0, 0, 0,  0,  'h02, 1, 0,  1, 1,  1, 'h02, 1, 1, 0, 0, 0, 2);
        vecs[20] = mk(1, 0, 0,  0,  'h03, 1, 0,  0, 0,  0, 'h00, 1, 0, 0, 0, 0, 0);
        vecs[21] = mk(0, 0, 0,  0,  'h04, 1, 0,  0, 0,  0, 'h00, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 22; i++) begin
            reset = vecs[i].rst; start = vecs[i].st;
            lower_bound = vecs[i].lo; upper_bound = vecs[i].hi;
            in_data = vecs[i].d; in_valid = vecs[i].v; in_last = vecs[i].l;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i),
                  32'({in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done,
                       error, error_code, count}),
                  32'(vecs[i].exp));
        end

        // Bubble load: in_valid toggles, one write strobe per handshake
        reset = 1'b0; start = 1'b1; lower_bound = 5'd0; upper_bound = 5'd31;
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        @(posedge clk); #1;
        check("start_ready", 32'({in_ready, cpu_reset, busy}), 32'(3'b111));
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = img[i / 2];
            in_last  = (i == 6);
            @(posedge clk); #1;
            check($sformatf("bub_we%0d", i), 32'(mem_we), 32'(i % 2 == 0));
            if (i % 2 == 0)
                check($sformatf("bub_wr%0d", i), 32'({mem_addr, mem_wdata}),
                      32'({5'(i / 2), img[i / 2]}));
            check($sformatf("bub_done%0d", i), 32'({done, cpu_reset}),
                  (i == 7) ? 32'(2'b10) : 32'(2'b01));
        end
        in_valid = 1'b0; in_last = 1'b0;
        check("bub_final", 32'({count, error, busy}), 32'({6'd4, 1'b0, 1'b0}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
